iddmm_sub_ctrl: RTL and testbench
=================================

# iddmm_sub_ctrl

Word-serial sequencer that drives the `iddmm_sub` borrow-chained subtractor interface to perform the Montgomery final conditional subtraction. It reads an N-word operand A and modulus M from a one-cycle-latency memory port, streams the words into the subtractor, and buffers both A and A−M. It then uses the final borrow to emit either A−M (A ≥ M) or A (A < M) as a valid/ready word stream. It sits between the IDDMM core result RAM and the downstream consumer.

## Interface
- K, 256, word width in bits
- N, 16, words per operand
- ADDR_W, $clog2(N), word address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- busy  out  1  high from FLUSH through EMIT
- done  out  1  one-cycle pulse after last output handshake
- rd_en  out  1  operand read strobe
- rd_addr  out  ADDR_W  operand word address
- rd_a  in  K  A word; valid the cycle after rd_en
- rd_m  in  K  M word; valid the cycle after rd_en
- sub_addr  out  ADDR_W  word index to subtractor
- sub_a  out  K  minuend word
- sub_b  out  K  subtrahend word
- borrow_bit  in  1  registered borrow from subtractor
- sub_result  in  K  registered difference word (1-cycle latency)
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accept
- out_addr  out  ADDR_W  output word index
- out_data  out  K  output word

## Operation
- States: IDLE → FLUSH → RUN → TAIL → EMIT → IDLE.
- IDLE: sub_addr held at N−1, sub_a = sub_b = 0. start → FLUSH.
- FLUSH (1 cycle):
  - sub_addr = 0, operands 0; the N−1→0 address transition clears the subtractor borrow.
  - rd_en = 1, rd_addr = 0.
- RUN (N cycles, r = 0..N−1):
  - sub_addr = r, sub_a = rd_a, sub_b = rd_m (combinational pass-through, gated to 0 outside RUN).
  - A buffer[r] ← rd_a.
  - rd_en = 1, rd_addr = r+1 for r < N−1; rd_en = 0 at r = N−1.
  - From r = 1, diff buffer[r−1] ← sub_result.
- TAIL (1 cycle):
  - sub_addr stays N−1, operands 0.
  - diff buffer[N−1] ← sub_result.
  - sel ← borrow_bit (final borrow; 1 means A < M).
- EMIT (N handshakes):
  - out_valid = 1; out_addr = index i.
  - out_data = sel ? A buffer[i] : diff buffer[i].
  - i advances only when out_valid & out_ready.
  - After handshake at i = N−1 → IDLE with done = 1 for that cycle.
- Arithmetic is done entirely in `iddmm_sub`. This block adds no carry logic; it only guarantees the address sequence so the borrow chain starts at 0 for word 0.
- Boundaries:
  - start while busy: ignored.
  - start in the done cycle: accepted.
  - out_ready low: out_addr and out_data held stable.
  - A == M gives sel = 0 and all-zero output.
  - Async reset mid-operation: immediate return to IDLE with reset values, buffers not cleared. The next operation is correct because FLUSH re-clears the borrow.
- Reset values: busy 0, done 0, rd_en 0, rd_addr 0, sub_addr N−1, sub_a 0, sub_b 0, out_valid 0, out_addr 0, out_data 0 (out_data gated by out_valid). sel 0.

## Timing
- start high in cycle 0 gives:
  - FLUSH in cycle 1.
  - RUN in cycles 2..N+1.
  - TAIL in cycle N+2.
  - First out_valid in cycle N+3.
- Minimum latency from start to done is 2N+3 cycles with out_ready held high.
- borrow_bit is sampled only in TAIL. It is garbage in all other cycles and must be ignored.
- busy rises the cycle after start is accepted and falls together with the done pulse.

## Structure
- Shared package `iddmm_pkg`: state enum `iddmm_sub_ctrl_state_t` (IDLE, FLUSH, RUN, TAIL, EMIT).
- Sub-module `iddmm_word_buf` (N×K registers, one synchronous write port, one asynchronous read port), instantiated twice: A buffer and diff buffer.

## Test plan
Directed scenarios at K = 8, N = 4, words listed LSW first:
- A = {10,00,00,05}, M = {20,FF,FF,04} → sel 0, out = {F0,00,00,00}, out_addr 0..3.
- A = {01,00,00,00}, M = {02,00,00,00} → sel 1, out = {01,00,00,00}.
- A = M = {AA,55,AA,55} → sel 0, out all 00.
- Back-to-back: case 2, then start in its done cycle with case 1 → second output {F0,00,00,00}, which proves the FLUSH cleared the borrow.
- out_ready low for 3 cycles at i = 2 during case 1 → out_addr = 2 and out_data = 00 held stable; done 2N+6 cycles after start.
- rst_n pulsed during RUN r = 1 → all outputs at reset values, sub_addr = 3; a subsequent case 1 run produces the correct result.

Source files
------------

// File: rtl/iddmm_pkg.sv
// Shared types for the IDDMM final-subtraction sequencer.
package iddmm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        TAIL,
        EMIT
    } iddmm_sub_ctrl_state_t;

endpackage

// File: rtl/iddmm_sub_ctrl_if.sv
// Operand-read, subtractor and output-stream signals of iddmm_sub_ctrl.
interface iddmm_sub_ctrl_if #(
    parameter int unsigned K      = 256,
    parameter int unsigned N      = 16,
    parameter int unsigned ADDR_W = $clog2(N)
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [K-1:0]      rd_a;
    logic [K-1:0]      rd_m;
    logic [ADDR_W-1:0] sub_addr;
    logic [K-1:0]      sub_a;
    logic [K-1:0]      sub_b;
    logic              borrow_bit;
    logic [K-1:0]      sub_result;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [K-1:0]      out_data;

    modport master (
        input  start, rd_a, rd_m, borrow_bit, sub_result, out_ready,
        output busy, done, rd_en, rd_addr, sub_addr, sub_a, sub_b,
               out_valid, out_addr, out_data
    );

    modport slave (
        output start, rd_a, rd_m, borrow_bit, sub_result, out_ready,
        input  busy, done, rd_en, rd_addr, sub_addr, sub_a, sub_b,
               out_valid, out_addr, out_data
    );
endinterface

// File: rtl/iddmm_word_buf.sv
// N x K word register file: one synchronous write port, one asynchronous read port.
module iddmm_word_buf #(
    parameter int unsigned K      = 256,
    parameter int unsigned N      = 16,
    parameter int unsigned ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [K-1:0]      i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [K-1:0]      o_rdata
);
    logic [K-1:0] r_mem [N];

    // Contents survive reset; every operation rewrites all N words before reading.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/iddmm_sub_ctrl.sv
// Montgomery final conditional subtraction sequencer: streams A and M through
// iddmm_sub, buffers A and A-M, then emits whichever the final borrow selects.
module iddmm_sub_ctrl
    import iddmm_pkg::*;
#(
    parameter int unsigned K      = 256,
    parameter int unsigned N      = 16,
    parameter int unsigned ADDR_W = $clog2(N)
) (
    input logic              clk,
    input logic              rst_n,
    iddmm_sub_ctrl_if.master sub_if
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    iddmm_sub_ctrl_state_t r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_idx;
    logic                  r_sel;
    logic                  r_done;
    logic                  w_hs;
    logic                  w_a_we, w_d_we;
    logic [ADDR_W-1:0]     w_d_waddr;
    logic [K-1:0]          w_a_rdata, w_d_rdata;

    assign w_hs = (r_state == EMIT) && sub_if.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        sub_if.rd_en     = 1'b0;
        sub_if.rd_addr   = '0;
        sub_if.sub_addr  = LAST;
        sub_if.sub_a     = '0;
        sub_if.sub_b     = '0;
        sub_if.out_valid = 1'b0;
        sub_if.out_addr  = '0;
        case (r_state)
            IDLE: begin
                if (sub_if.start) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                // LAST -> 0 on sub_addr is what clears the subtractor borrow.
                sub_if.sub_addr = '0;
                sub_if.rd_en    = 1'b1;
                w_state_nxt     = RUN;
            end
            RUN: begin
                sub_if.sub_addr = r_idx;
                sub_if.sub_a    = sub_if.rd_a;
                sub_if.sub_b    = sub_if.rd_m;
                if (r_idx == LAST) begin
                    w_state_nxt = TAIL;
                end else begin
                    sub_if.rd_en   = 1'b1;
                    sub_if.rd_addr = r_idx + 1'b1;
                end
            end
            TAIL: begin
                w_state_nxt = EMIT;
            end
            EMIT: begin
                sub_if.out_valid = 1'b1;
                sub_if.out_addr  = r_idx;
                if (w_hs && (r_idx == LAST)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_sel  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs && (r_idx == LAST);
            case (r_state)
                RUN:     r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
                TAIL: begin
                    r_idx <= '0;
                    r_sel <= sub_if.borrow_bit;
                end
                EMIT:    if (w_hs) r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
                default: r_idx <= '0;
            endcase
        end
    end

    assign sub_if.busy = (r_state != IDLE);
    assign sub_if.done = r_done;

    // Difference words arrive one cycle behind their operands, so the diff
    // buffer trails the A buffer by one slot and takes the last word in TAIL.
    assign w_a_we    = (r_state == RUN);
    assign w_d_we    = ((r_state == RUN) && (r_idx != '0)) || (r_state == TAIL);
    assign w_d_waddr = (r_state == TAIL) ? LAST : r_idx - 1'b1;

    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_a_buf (
        .clk     (clk),
        .i_we    (w_a_we),
        .i_waddr (r_idx),
        .i_wdata (sub_if.rd_a),
        .i_raddr (r_idx),
        .o_rdata (w_a_rdata)
    );

    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_d_buf (
        .clk     (clk),
        .i_we    (w_d_we),
        .i_waddr (w_d_waddr),
        .i_wdata (sub_if.sub_result),
        .i_raddr (r_idx),
        .o_rdata (w_d_rdata)
    );

    assign sub_if.out_data = !sub_if.out_valid ? '0 : (r_sel ? w_a_rdata : w_d_rdata);
endmodule

// File: tb/tb_iddmm_sub_ctrl.sv
// Bench for iddmm_sub_ctrl at K=8, N=4 with a behavioural memory, subtractor and result model.
module tb_iddmm_sub_ctrl;
    localparam int unsigned K  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned W  = K * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iddmm_sub_ctrl_if #(.K(K), .N(N), .ADDR_W(AW)) bus ();

    iddmm_sub_ctrl #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sub_if (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Operand memory: one-cycle read latency.
    logic [K-1:0] mem_a [N];
    logic [K-1:0] mem_m [N];
    logic [K-1:0] r_rd_a = '0, r_rd_m = '0;
    always @(posedge clk) begin
        if (bus.rd_en) begin
            r_rd_a <= mem_a[bus.rd_addr];
            r_rd_m <= mem_m[bus.rd_addr];
        end
    end
    assign bus.rd_a = r_rd_a;
    assign bus.rd_m = r_rd_m;

    // Subtractor: registered borrow chain, cleared on a sub_addr N-1 -> 0 step.
    logic [AW-1:0] r_prev_addr = AW'(N - 1);
    logic          r_borrow    = 1'b0;
    logic [K-1:0]  r_diff      = '0;
    logic [K:0]    t_d;
    always @(posedge clk) begin
        if (bus.sub_addr == '0 && r_prev_addr == AW'(N - 1)) begin
            r_borrow <= 1'b0;
            r_diff   <= '0;
        end else begin
            t_d = {1'b0, bus.sub_a} - {1'b0, bus.sub_b} - {{K{1'b0}}, r_borrow};
            r_borrow <= t_d[K];
            r_diff   <= t_d[K-1:0];
        end
        r_prev_addr <= bus.sub_addr;
    end
    assign bus.borrow_bit = r_borrow;
    assign bus.sub_result = r_diff;

    function automatic logic [W-1:0] ref_out(input logic [W-1:0] a, input logic [W-1:0] m);
        return (a >= m) ? a - m : a;
    endfunction

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] m);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = a[i*K +: K];
            mem_m[i] = m[i*K +: K];
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"},      bus.busy,      0);
        check({tag, ".done"},      bus.done,      0);
        check({tag, ".rd_en"},     bus.rd_en,     0);
        check({tag, ".rd_addr"},   bus.rd_addr,   0);
        check({tag, ".sub_addr"},  bus.sub_addr,  N - 1);
        check({tag, ".sub_a"},     bus.sub_a,     0);
        check({tag, ".sub_b"},     bus.sub_b,     0);
        check({tag, ".out_valid"}, bus.out_valid, 0);
        check({tag, ".out_addr"},  bus.out_addr,  0);
        check({tag, ".out_data"},  bus.out_data,  0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle.busy", bus.busy, 0);
            check("idle.done", bus.done, 0);
            check("idle.sub_addr", bus.sub_addr, N - 1);
            check("idle.out_valid", bus.out_valid, 0);
        end
    endtask

    // Entered on a negedge with the DUT in IDLE (cycle 0); returns on the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] m, input int stall_at,
                          input int stall_len, input bit rnd_ready, input bit poke_start);
        logic [W-1:0] e;
        logic [K-1:0] ew;
        int  h, stalls, rem;
        bit  fin, exp_done, exp_valid, run, rdy;
        e = ref_out(a, m);
        load(a, m);
        bus.start = 1'b1;
        h = 0; stalls = 0; rem = stall_len; fin = 1'b0;
        for (int c = 1; c < 200 && !fin; c++) begin
            @(negedge clk);
            bus.start = poke_start && (c == 5);
            exp_done  = (c == 2 * N + 3 + stalls);
            exp_valid = (c >= N + 3) && !exp_done;
            run       = (c >= 2) && (c <= N + 1);
            check("done", bus.done, exp_done);
            check("busy", bus.busy, !exp_done);
            check("sub_addr", bus.sub_addr, (c == 1) ? 0 : run ? c - 2 : N - 1);
            check("rd_en", bus.rd_en, (c <= N));
            check("rd_addr", bus.rd_addr, (c <= N) ? c - 1 : 0);
            check("sub_a", bus.sub_a, run ? a[(c-2)*K +: K] : 0);
            check("sub_b", bus.sub_b, run ? m[(c-2)*K +: K] : 0);
            check("out_valid", bus.out_valid, exp_valid);
            if (exp_valid) begin
                ew = e[h*K +: K];
                check("out_addr", bus.out_addr, h);
                check("out_data", bus.out_data, ew);
                if (h == stall_at && rem > 0) begin
                    rdy = 1'b0;
                    rem--;
                end else if (rnd_ready) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end else begin
                    rdy = 1'b1;
                end
                bus.out_ready = rdy;
                if (rdy) h++;
                else stalls++;
            end else begin
                check("out_data_gated", bus.out_data, 0);
                bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (exp_done) fin = 1'b1;
        end
        if (!fin) check("timeout", 0, 1);
    endtask

    localparam logic [W-1:0] C1_A = 32'h0500_0010, C1_M = 32'h04FF_FF20;
    localparam logic [W-1:0] C2_A = 32'h0000_0001, C2_M = 32'h0000_0002;
    localparam logic [W-1:0] C3_A = 32'h55AA_55AA;

    initial begin
        logic [W-1:0] ra, rm;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        load('0, '0);
        #3;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        run_op(C1_A, C1_M, -1, 0, 1'b0, 1'b0);
        idle(1);
        run_op(C2_A, C2_M, -1, 0, 1'b0, 1'b0);
        idle(1);
        run_op(C3_A, C3_A, -1, 0, 1'b0, 1'b0);
        idle(1);
        // Back-to-back: second start issued in the done cycle of the first.
        run_op(C2_A, C2_M, -1, 0, 1'b0, 1'b0);
        run_op(C1_A, C1_M, -1, 0, 1'b0, 1'b0);
        idle(1);
        run_op(C1_A, C1_M, 2, 3, 1'b0, 1'b0);
        idle(1);
        // start while busy must be ignored.
        run_op(C2_A, C2_M, -1, 0, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset during RUN r=1.
        load(C2_A, C2_M);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        run_op(C1_A, C1_M, -1, 0, 1'b0, 1'b0);
        idle(1);

        for (int t = 0; t < 24; t++) begin
            ra = W'($urandom);
            case (t % 4)
                0: rm = ra;
                1: rm = ra + 1;
                2: rm = ra - 1;
                default: rm = W'($urandom);
            endcase
            run_op(ra, rm, -1, 0, 1'b1, 1'b0);
            if (t % 3 == 0) idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
